// File: rtl/clock_group_pkg.sv
// Shared types and helpers for the clock-group member-side reset sequencer.
package clock_group_pkg;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        WAIT_RDY = 3'd1,
        GAP      = 3'd2,
        UP       = 3'd3,
        ERR      = 3'd4
    } state_e;

    localparam int DEF_N_MEMBERS      = 4;
    localparam int DEF_STRETCH_CYCLES = 16;
    localparam int DEF_GAP_CYCLES     = 4;
    localparam int DEF_READY_TIMEOUT  = 255;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clock_group_reset_sink_seq_counter.sv
// Up-counter shared by the stretch, gap and ready-timeout intervals of the sequencer.
module reset_seq_counter #(
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] term_i,
    output logic          match_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_o = (cnt_q == term_i);

endmodule

// File: rtl/clock_group_reset_sink.sv
// Member-side reset sequencer: releases member resets in order, watches readiness,
// and re-runs the sequence on a software request.
module clock_group_reset_sink
    import clock_group_pkg::*;
#(
    parameter  int N_MEMBERS      = DEF_N_MEMBERS,
    parameter  int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter  int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter  int READY_TIMEOUT  = DEF_READY_TIMEOUT,
    localparam int CW             = clog2(max3(STRETCH_CYCLES, GAP_CYCLES, READY_TIMEOUT) + 1),
    localparam int IW             = clog2(N_MEMBERS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_MEMBERS-1:0] member_ready,
    input  logic                 soft_req,
    output logic                 soft_ack,
    output logic [N_MEMBERS-1:0] member_reset,
    output logic                 all_up,
    output logic                 timeout_err,
    output logic [IW-1:0]        fail_idx
);

    localparam logic [CW-1:0] STRETCH_TERM = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_TERM     = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] TO_TERM      = CW'(READY_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX     = IW'(N_MEMBERS - 1);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   soft_pending_q, soft_pending_d;
    logic [N_MEMBERS-1:0]   member_reset_q, member_reset_d;
    logic                   all_up_q, all_up_d;
    logic                   soft_ack_q, soft_ack_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [IW-1:0]          fail_idx_q, fail_idx_d;

    logic                   cnt_clr;
    logic                   cnt_en;
    logic [CW-1:0]          cnt_term;
    logic                   cnt_match;
    logic                   soft_accept;
    logic                   ready_cur;
    logic [IW-1:0]          drop_idx;

    function automatic logic [IW-1:0] lowest_zero(input logic [N_MEMBERS-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = N_MEMBERS - 1; i >= 0; i--) begin
            if (!v[i]) r = IW'(i);
        end
        return r;
    endfunction

    reset_seq_counter #(
        .CW (CW)
    ) u_counter (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .term_i  (cnt_term),
        .match_o (cnt_match)
    );

    assign soft_accept = soft_req && ((state_q == UP) || (state_q == ERR));
    assign ready_cur   = member_ready[idx_q];
    assign drop_idx    = lowest_zero(member_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= HOLD;
            idx_q          <= '0;
            soft_pending_q <= 1'b0;
            member_reset_q <= '1;
            all_up_q       <= 1'b0;
            soft_ack_q     <= 1'b0;
            timeout_err_q  <= 1'b0;
            fail_idx_q     <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            soft_pending_q <= soft_pending_d;
            member_reset_q <= member_reset_d;
            all_up_q       <= all_up_d;
            soft_ack_q     <= soft_ack_d;
            timeout_err_q  <= timeout_err_d;
            fail_idx_q     <= fail_idx_d;
        end
    end

    // Ready takes priority over the timeout match when both land on one cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        cnt_term = STRETCH_TERM;
        case (state_q)
            HOLD: begin
                cnt_term = STRETCH_TERM;
                if (cnt_match) begin
                    state_d = WAIT_RDY;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            WAIT_RDY: begin
                cnt_term = TO_TERM;
                if (ready_cur) begin
                    cnt_clr = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = UP;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (cnt_match) begin
                    state_d = ERR;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            GAP: begin
                cnt_term = GAP_TERM;
                if (cnt_match) begin
                    state_d = WAIT_RDY;
                    idx_d   = idx_q + IW'(1);
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            UP: begin
                cnt_clr = 1'b1;
                if (soft_accept) begin
                    state_d = HOLD;
                    idx_d   = '0;
                end else if (!(&member_ready)) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                cnt_clr = 1'b1;
                if (soft_accept) begin
                    state_d = HOLD;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = HOLD;
                idx_d   = '0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        member_reset_d = member_reset_q;
        timeout_err_d  = timeout_err_q;
        fail_idx_d     = fail_idx_q;
        soft_pending_d = soft_pending_q;
        soft_ack_d     = 1'b0;
        all_up_d       = (state_d == UP);
        case (state_q)
            HOLD: begin
                if (state_d == WAIT_RDY) member_reset_d[0] = 1'b0;
            end
            WAIT_RDY: begin
                if (state_d == ERR) begin
                    member_reset_d[idx_q] = 1'b1;
                    timeout_err_d         = 1'b1;
                    fail_idx_d            = idx_q;
                end else if (idx_d != idx_q) begin
                    member_reset_d[idx_d] = 1'b0;
                end
            end
            GAP: begin
                if (state_d == WAIT_RDY) member_reset_d[idx_d] = 1'b0;
            end
            UP, ERR: begin
                if (soft_accept) begin
                    member_reset_d = '1;
                    timeout_err_d  = 1'b0;
                    fail_idx_d     = '0;
                    soft_pending_d = 1'b1;
                end else if ((state_q == UP) && (state_d == ERR)) begin
                    member_reset_d[drop_idx] = 1'b1;
                    timeout_err_d            = 1'b1;
                    fail_idx_d               = drop_idx;
                end
            end
            default: begin
                member_reset_d = '1;
            end
        endcase
        // Acknowledge only the first arrival in UP/ERR after a soft-started run.
        if (soft_pending_q && ((state_d == UP) || (state_d == ERR)) &&
            (state_q != UP) && (state_q != ERR)) begin
            soft_ack_d     = 1'b1;
            soft_pending_d = 1'b0;
        end
    end

    assign soft_ack     = soft_ack_q;
    assign member_reset = member_reset_q;
    assign all_up       = all_up_q;
    assign timeout_err  = timeout_err_q;
    assign fail_idx     = fail_idx_q;

endmodule

// File: tb/tb_clock_group_reset_sink.sv
// Bench for clock_group_reset_sink: two instances (gap 4 and gap 0) against a behavioural model.
module tb_clock_group_reset_sink;

    localparam int N       = 4;
    localparam int STRETCH = 16;
    localparam int TMO     = 8;
    localparam int GAP_A   = 4;
    localparam int GAP_B   = 0;
    localparam int RDY_LAT = 3;

    localparam int P_STRETCH = 0;
    localparam int P_WAIT    = 1;
    localparam int P_GAP     = 2;
    localparam int P_UP      = 3;
    localparam int P_FAIL    = 4;

    typedef struct packed {
        int         phase;
        int         left;
        int         cur;
        logic [3:0] rst;
        bit         up;
        bit         ack;
        bit         err;
        int         fidx;
        bit         pend;
    } mdl_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rdy_a = 4'h0, rdy_b = 4'h0;
    logic       sreq_a = 1'b0, sreq_b = 1'b0;
    logic [3:0] mr_a, mr_b;
    logic       up_a, up_b, ack_a, ack_b, err_a, err_b;
    logic [1:0] fi_a, fi_b;

    mdl_t       m [2];
    int         age [2][4];
    logic [3:0] broken [2];
    logic [3:0] next_broken [2];
    logic [3:0] dropped [2];
    bit         sq_hold [2];
    int         total, bad;
    int         acks_a, acks_b;

    always #5 clock = ~clock;

    clock_group_reset_sink #(
        .N_MEMBERS(N), .STRETCH_CYCLES(STRETCH), .GAP_CYCLES(GAP_A), .READY_TIMEOUT(TMO)
    ) dut_a (
        .clock(clock), .reset(reset), .member_ready(rdy_a), .soft_req(sreq_a),
        .soft_ack(ack_a), .member_reset(mr_a), .all_up(up_a), .timeout_err(err_a), .fail_idx(fi_a)
    );

    clock_group_reset_sink #(
        .N_MEMBERS(N), .STRETCH_CYCLES(STRETCH), .GAP_CYCLES(GAP_B), .READY_TIMEOUT(TMO)
    ) dut_b (
        .clock(clock), .reset(reset), .member_ready(rdy_b), .soft_req(sreq_b),
        .soft_ack(ack_b), .member_reset(mr_b), .all_up(up_b), .timeout_err(err_b), .fail_idx(fi_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp_v, $time);
        end
    endtask

    // Reference: timers count down the cycles left in the current interval.
    function automatic mdl_t step(input mdl_t m0, input logic r, input logic [3:0] rdy,
                                  input logic sq, input int gap);
        mdl_t n;
        n = m0;
        n.ack = 1'b0;
        if (r) begin
            n.phase = P_STRETCH; n.left = STRETCH; n.cur = 0; n.rst = 4'hF;
            n.up = 1'b0; n.err = 1'b0; n.fidx = 0; n.pend = 1'b0;
            return n;
        end
        case (m0.phase)
            P_STRETCH: begin
                n.left = m0.left - 1;
                if (n.left == 0) begin
                    n.rst[0] = 1'b0; n.phase = P_WAIT; n.left = TMO;
                end
            end
            P_WAIT: begin
                if (rdy[m0.cur]) begin
                    if (m0.cur == N - 1) n.phase = P_UP;
                    else if (gap > 0) begin
                        n.phase = P_GAP; n.left = gap;
                    end else begin
                        n.cur = m0.cur + 1; n.rst[n.cur] = 1'b0; n.left = TMO;
                    end
                end else begin
                    n.left = m0.left - 1;
                    if (n.left == 0) begin
                        n.phase = P_FAIL; n.err = 1'b1; n.fidx = m0.cur; n.rst[m0.cur] = 1'b1;
                    end
                end
            end
            P_GAP: begin
                n.left = m0.left - 1;
                if (n.left == 0) begin
                    n.cur = m0.cur + 1; n.rst[n.cur] = 1'b0; n.phase = P_WAIT; n.left = TMO;
                end
            end
            default: begin
                if (sq) begin
                    n.phase = P_STRETCH; n.left = STRETCH; n.cur = 0; n.rst = 4'hF;
                    n.err = 1'b0; n.fidx = 0; n.pend = 1'b1;
                end else if (m0.phase == P_UP && rdy != 4'hF) begin
                    n.phase = P_FAIL; n.err = 1'b1;
                    for (int i = N - 1; i >= 0; i--) if (!rdy[i]) n.fidx = i;
                    n.rst[n.fidx] = 1'b1;
                end
            end
        endcase
        n.up = (n.phase == P_UP);
        if (n.pend && (n.phase == P_UP || n.phase == P_FAIL)) begin
            n.ack = 1'b1; n.pend = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_of(input mdl_t mm);
        return {23'b0, mm.rst, mm.up, mm.ack, mm.err, 2'(mm.fidx)};
    endfunction

    function automatic logic [31:0] obs(input int d);
        if (d == 0) return {23'b0, mr_a, up_a, ack_a, err_a, fi_a};
        return {23'b0, mr_b, up_b, ack_b, err_b, fi_b};
    endfunction

    task automatic tick();
        logic [3:0] r [2];
        mdl_t       prev;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++)
                r[d][i] = !m[d].rst[i] && (age[d][i] >= RDY_LAT) && !broken[d][i] && !dropped[d][i];
        rdy_a  = r[0];
        rdy_b  = r[1];
        sreq_a = sq_hold[0];
        sreq_b = sq_hold[1];
        @(posedge clock);
        for (int d = 0; d < 2; d++) begin
            prev = m[d];
            m[d] = step(m[d], reset, (d == 0) ? rdy_a : rdy_b, (d == 0) ? sreq_a : sreq_b,
                        (d == 0) ? GAP_A : GAP_B);
            for (int i = 0; i < N; i++) begin
                if (m[d].rst[i]) age[d][i] = 0;
                else if (age[d][i] < 100) age[d][i]++;
            end
            if (reset || (m[d].phase == P_STRETCH && (prev.phase == P_UP || prev.phase == P_FAIL))) begin
                dropped[d] = 4'h0;
                broken[d]  = next_broken[d];
            end
            if (reset || m[d].ack) sq_hold[d] = 1'b0;
        end
        #1;
        chk("dut_a", obs(0), exp_of(m[0]));
        chk("dut_b", obs(1), exp_of(m[1]));
        acks_a += int'(ack_a);
        acks_b += int'(ack_b);
    endtask

    initial begin
        int k, rel0, rel1a, rel1b;
        total = 0; bad = 0; acks_a = 0; acks_b = 0;
        for (int d = 0; d < 2; d++) begin
            m[d] = '0; broken[d] = 4'h0; next_broken[d] = 4'h0; dropped[d] = 4'h0; sq_hold[d] = 1'b0;
            for (int i = 0; i < N; i++) age[d][i] = 0;
        end

        reset = 1'b1;
        repeat (5) begin
            tick();
            chk("rst_a", obs(0), 32'h1E0);
            chk("rst_b", obs(1), 32'h1E0);
        end
        reset = 1'b0;

        // cold boot
        rel0 = -1; rel1a = -1; rel1b = -1; k = 0; acks_a = 0; acks_b = 0;
        while (!(m[0].up && m[1].up) && k < 400) begin
            tick();
            k++;
            if (rel0 < 0 && !mr_a[0]) rel0 = k;
            if (rel1a < 0 && !mr_a[1]) rel1a = k;
            if (rel1b < 0 && !mr_b[1]) rel1b = k;
        end
        chk("rel0_edge", rel0, STRETCH);
        chk("rel1_gap_a", rel1a - rel0, RDY_LAT + GAP_A);
        chk("rel1_gap_b", rel1b - rel0, RDY_LAT + GAP_B);
        chk("boot_up_a", up_a, 1);
        chk("boot_noack", acks_a + acks_b, 0);

        // member 2 never comes up
        next_broken[0] = 4'b0100; next_broken[1] = 4'b0100;
        sq_hold[0] = 1'b1; sq_hold[1] = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!(m[0].phase == P_FAIL && m[1].phase == P_FAIL) && k < 400);
        chk("to_mr_a", mr_a, 4'b1100);
        chk("to_mr_b", mr_b, 4'b1100);
        chk("to_idx", fi_a, 2);
        chk("to_err", err_a, 1);
        chk("to_up", up_a, 0);

        // recover via soft request
        next_broken[0] = 4'h0; next_broken[1] = 4'h0;
        acks_a = 0; acks_b = 0;
        sq_hold[0] = 1'b1; sq_hold[1] = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!(m[0].up && m[1].up) && k < 400);
        repeat (5) tick();
        chk("rec_ack_a", acks_a, 1);
        chk("rec_ack_b", acks_b, 1);
        chk("rec_err", err_a, 0);
        chk("rec_up", up_a, 1);

        // two members drop at once in UP
        dropped[0] = 4'b1010;
        k = 0;
        do begin tick(); k++; end while (m[0].phase != P_FAIL && k < 10);
        chk("drop_idx", fi_a, 1);
        chk("drop_mr", mr_a, 4'b0010);

        // reset while gapping after member 1
        sq_hold[0] = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!(m[0].phase == P_GAP && m[0].cur == 1) && k < 400);
        reset = 1'b1;
        tick();
        chk("gap_rst", obs(0), 32'h1E0);
        reset = 1'b0;
        k = 0;
        do begin tick(); k++; end while (!m[0].up && k < 400);
        chk("gap_rst_up", up_a, 1);

        // soft request raised mid-sequence is held until UP
        reset = 1'b1;
        tick();
        reset = 1'b0;
        k = 0;
        do begin tick(); k++; end while (m[1].phase != P_WAIT && k < 100);
        sq_hold[1] = 1'b1;
        acks_b = 0;
        k = 0;
        do begin tick(); k++; end while (!m[1].up && k < 400);
        chk("wr_noack", acks_b, 0);
        k = 0;
        do begin tick(); k++; end while (acks_b == 0 && k < 400);
        repeat (6) tick();
        chk("wr_ack_b", acks_b, 1);
        chk("wr_up_b", up_b, 1);

        // randomized traffic
        for (int c = 0; c < 20000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int d = 0; d < 2; d++) begin
                if (m[d].phase == P_UP && !sq_hold[d] && $urandom_range(0, 29) == 0) begin
                    if ($urandom_range(0, 1) == 1) dropped[d] = dropped[d] | 4'($urandom_range(1, 15));
                    else sq_hold[d] = 1'b1;
                end
                if (m[d].phase == P_FAIL && $urandom_range(0, 9) == 0) sq_hold[d] = 1'b1;
                if (m[d].phase < P_UP && $urandom_range(0, 199) == 0) sq_hold[d] = 1'b1;
                next_broken[d] = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
